// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetchState_e;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;
  localparam int unsigned PC_INCR      = 4;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load a fetched word, hold it, or replace it with a bubble.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     bubble,
  input  logic                     drop,
  input  logic [DATA_WIDTH-1:0]    instrIn,
  input  logic [ADDRESS_WIDTH-1:0] pcIn,
  input  logic [ADDRESS_WIDTH-1:0] pcPlus4In,
  output logic [DATA_WIDTH-1:0]    instrOut,
  output logic [ADDRESS_WIDTH-1:0] pcOut,
  output logic [ADDRESS_WIDTH-1:0] pcPlus4Out,
  output logic                     validOut
);

  // bubble > load > drop (keep contents, clear valid) > hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instrOut   <= DATA_WIDTH'(NOP_INSTR);
      pcOut      <= '0;
      pcPlus4Out <= '0;
      validOut   <= 1'b0;
    end else if (bubble) begin
      instrOut <= DATA_WIDTH'(NOP_INSTR);
      validOut <= 1'b0;
    end else if (load) begin
      instrOut   <= instrIn;
      pcOut      <= pcIn;
      pcPlus4Out <= pcPlus4In;
      validOut   <= 1'b1;
    end else if (drop) begin
      validOut <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC and the IDLE/RUN/HALT control FSM.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic [ADDRESS_WIDTH-1:0] pc_f,
  input  logic [DATA_WIDTH-1:0]    instr_f,
  output logic [DATA_WIDTH-1:0]    instr_d,
  output logic [ADDRESS_WIDTH-1:0] pc_d,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
  output logic                     valid_d,
  output logic                     halted,
  output logic                     misaligned
);

  fetchState_e state, stateNext;
  logic [ADDRESS_WIDTH-1:0] pcNext;
  logic [ADDRESS_WIDTH-1:0] pcPlus4;
  logic misalignedNext;
  logic regLoad, regBubble, regDrop;

  assign pcPlus4 = pc_f + ADDRESS_WIDTH'(PC_INCR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc_f       <= '0;
      misaligned <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state      <= stateNext;
      pc_f       <= pcNext;
      misaligned <= misalignedNext;
      halted     <= (stateNext == HALT);
    end
  end

  always_comb begin
    stateNext      = state;
    pcNext         = pc_f;
    misalignedNext = misaligned;
    regLoad        = 1'b0;
    regBubble      = 1'b0;
    regDrop        = 1'b0;
    unique case (state)
      IDLE: begin
        regDrop = 1'b1;
        if (start) stateNext = RUN;
      end
      RUN: begin
        if (redirect) begin
          regBubble = 1'b1;
          if (redirect_pc[1:0] != 2'b00) begin
            misalignedNext = 1'b1;
            stateNext      = HALT;
          end else begin
            pcNext = redirect_pc;
          end
        end else if (!stall) begin
          regLoad = 1'b1;
          // EBREAK is still captured as a valid instruction; only the PC freezes
          if (instr_f == DATA_WIDTH'(EBREAK_INSTR)) stateNext = HALT;
          else                                      pcNext    = pcPlus4;
        end
      end
      HALT: regDrop = 1'b1;
      default: begin
        stateNext = IDLE;
        regDrop   = 1'b1;
      end
    endcase
  end

  if_id_reg #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_ifId (
    .clk       (clk),
    .rst       (rst),
    .load      (regLoad),
    .bubble    (regBubble),
    .drop      (regDrop),
    .instrIn   (instr_f),
    .pcIn      (pc_f),
    .pcPlus4In (pcPlus4),
    .instrOut  (instr_d),
    .pcOut     (pc_d),
    .pcPlus4Out(pc_plus4_d),
    .validOut  (valid_d)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational instruction memory model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] pc_f;
  logic [31:0] instr_f;
  logic [31:0] instr_d;
  logic [15:0] pc_d;
  logic [15:0] pc_plus4_d;
  logic        valid_d;
  logic        halted;
  logic        misaligned;

  logic [31:0] mem [0:16383];

  int unsigned nChecks = 0;
  int unsigned nPass   = 0;

  always #5 clk = ~clk;

  assign instr_f = mem[pc_f[15:2]];

  fetch_stage #(
    .ADDRESS_WIDTH(16),
    .DATA_WIDTH   (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .pc_f       (pc_f),
    .instr_f    (instr_f),
    .instr_d    (instr_d),
    .pc_d       (pc_d),
    .pc_plus4_d (pc_plus4_d),
    .valid_d    (valid_d),
    .halted     (halted),
    .misaligned (misaligned)
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    checkEq({tag, ".pc_f"}, 32'(pc_f), 32'h0);
    checkEq({tag, ".instr_d"}, instr_d, 32'h0000_0013);
    checkEq({tag, ".pc_d"}, 32'(pc_d), 32'h0);
    checkEq({tag, ".pc_plus4_d"}, 32'(pc_plus4_d), 32'h0);
    checkEq({tag, ".valid_d"}, 32'(valid_d), 32'h0);
    checkEq({tag, ".misaligned"}, 32'(misaligned), 32'h0);
    checkEq({tag, ".halted"}, 32'(halted), 32'h0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
  endtask

  task automatic startRun();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h1000_0000 | 32'(i << 2);
    mem[0] = 32'h00A0_0093;
    mem[1] = 32'h0010_0113;
    mem[4] = 32'h0010_0073;

    start = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    rst = 1'b1;
    #3;
    checkReset("rst");
    tick();
    rst = 1'b0;

    // IDLE ignores stall/redirect and holds
    redirect = 1'b1; redirect_pc = 16'h0040; stall = 1'b1;
    tick();
    redirect = 1'b0; stall = 1'b0;
    checkEq("idle.pc_f", 32'(pc_f), 32'h0);
    checkEq("idle.valid", 32'(valid_d), 32'h0);

    // Basic fetch
    startRun();
    checkEq("start.valid", 32'(valid_d), 32'h0);
    checkEq("start.halted", 32'(halted), 32'h0);
    tick();
    checkEq("f0.valid", 32'(valid_d), 32'h1);
    checkEq("f0.pc_d", 32'(pc_d), 32'h0);
    checkEq("f0.instr_d", instr_d, 32'h00A0_0093);
    checkEq("f0.pc_plus4_d", 32'(pc_plus4_d), 32'h4);
    tick();
    checkEq("f1.pc_d", 32'(pc_d), 32'h4);
    checkEq("f1.instr_d", instr_d, 32'h0010_0113);
    checkEq("f1.pc_f", 32'(pc_f), 32'h8);

    // Stall three cycles at 0x0008
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkEq("stall.pc_f", 32'(pc_f), 32'h8);
      checkEq("stall.pc_d", 32'(pc_d), 32'h4);
      checkEq("stall.instr_d", instr_d, 32'h0010_0113);
      checkEq("stall.valid", 32'(valid_d), 32'h1);
    end
    stall = 1'b0;
    tick();
    checkEq("unstall.pc_d", 32'(pc_d), 32'h8);
    checkEq("unstall.instr_d", instr_d, 32'h1000_0008);
    checkEq("unstall.pc_f", 32'(pc_f), 32'hC);

    // Redirect wins over stall
    redirect = 1'b1; redirect_pc = 16'h0040; stall = 1'b1;
    tick();
    redirect = 1'b0; stall = 1'b0;
    checkEq("redir.pc_f", 32'(pc_f), 32'h40);
    checkEq("redir.valid", 32'(valid_d), 32'h0);
    checkEq("redir.instr_d", instr_d, 32'h0000_0013);
    tick();
    checkEq("redir1.pc_d", 32'(pc_d), 32'h40);
    checkEq("redir1.valid", 32'(valid_d), 32'h1);
    checkEq("redir1.pc_f", 32'(pc_f), 32'h44);

    // PC wrap at 0xFFFC
    redirect = 1'b1; redirect_pc = 16'hFFFC;
    tick();
    redirect = 1'b0;
    checkEq("wrap.pc_f0", 32'(pc_f), 32'hFFFC);
    tick();
    checkEq("wrap.pc_f", 32'(pc_f), 32'h0);
    checkEq("wrap.pc_d", 32'(pc_d), 32'hFFFC);
    checkEq("wrap.pc_plus4_d", 32'(pc_plus4_d), 32'h0);
    checkEq("wrap.instr_d", instr_d, 32'h1000_FFFC);

    // Async reset mid-cycle, observed before the next edge
    #2;
    rst = 1'b1;
    #1;
    checkReset("async");
    tick();
    rst = 1'b0;
    #2;

    // EBREAK at 0x0010 after restarting from address 0
    startRun();
    tick();
    checkEq("restart.pc_d", 32'(pc_d), 32'h0);
    checkEq("restart.instr_d", instr_d, 32'h00A0_0093);
    for (int i = 0; i < 3; i++) tick();
    checkEq("pre_ebreak.pc_f", 32'(pc_f), 32'h10);
    checkEq("pre_ebreak.halted", 32'(halted), 32'h0);
    tick();
    checkEq("ebreak.instr_d", instr_d, 32'h0010_0073);
    checkEq("ebreak.valid", 32'(valid_d), 32'h1);
    checkEq("ebreak.halted", 32'(halted), 32'h1);
    checkEq("ebreak.pc_f", 32'(pc_f), 32'h10);
    checkEq("ebreak.pc_d", 32'(pc_d), 32'h10);
    tick();
    checkEq("ebreak1.valid", 32'(valid_d), 32'h0);
    checkEq("ebreak1.halted", 32'(halted), 32'h1);
    checkEq("ebreak1.pc_f", 32'(pc_f), 32'h10);
    checkEq("ebreak1.instr_d", instr_d, 32'h0010_0073);

    // Misaligned redirect halts and is sticky
    doReset();
    startRun();
    tick();
    checkEq("mis.pre_pc_f", 32'(pc_f), 32'h4);
    redirect = 1'b1; redirect_pc = 16'h0042;
    tick();
    redirect = 1'b0;
    checkEq("mis.flag", 32'(misaligned), 32'h1);
    checkEq("mis.halted", 32'(halted), 32'h1);
    checkEq("mis.pc_f", 32'(pc_f), 32'h4);
    checkEq("mis.valid", 32'(valid_d), 32'h0);
    checkEq("mis.instr_d", instr_d, 32'h0000_0013);
    start = 1'b1; redirect = 1'b1; redirect_pc = 16'h0080;
    tick();
    tick();
    start = 1'b0; redirect = 1'b0;
    checkEq("mis.ign_pc_f", 32'(pc_f), 32'h4);
    checkEq("mis.ign_halted", 32'(halted), 32'h1);
    checkEq("mis.ign_valid", 32'(valid_d), 32'h0);
    checkEq("mis.ign_flag", 32'(misaligned), 32'h1);

    // Reset clears HALT and the sticky flag
    rst = 1'b1;
    #1;
    checkReset("halt_rst");
    tick();
    rst = 1'b0;

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
